// File: rtl/hypervisor_ctrl.sv
// hypervisor_ctrl: decodes the 64-byte hypervisor window ($D640-$D67F),
// holds the user-context shadow registers, raises the hypervisor trap and
// streams the shadow bytes back to the CPU on hypervisor exit.
// Optional feature macro: HYPER_USER_TRAP_EN. When it is defined, user-mode
// writes to the window latch a trap reason and raise hyp. When it is not
// defined, hyp is tied low and user-mode writes are ignored.
module hypervisor_ctrl #(
    parameter int NUM_SHADOW = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hyper_cs,
    input  logic [7:0] hyper_addr,
    input  logic [7:0] hyper_io_data_i,
    output logic [7:0] hyper_data_o,
    input  logic       cpu_write,
    input  logic       ready,
    input  logic       hyper_mode,
    output logic       hyp,
    output logic       load_user_reg,
    output logic [7:0] user_mapper_reg
);

    localparam logic [5:0] OFF_REASON = 6'h3E;
    localparam logic [5:0] OFF_EXIT   = 6'h3F;
    localparam int         IDX_W      = (NUM_SHADOW > 1) ? $clog2(NUM_SHADOW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SHADOW - 1);

    typedef enum logic {
        S_IDLE,
        S_RESTORE
    } state_t;

    logic [7:0]       regs_reg [64];
    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [5:0] offset;
    logic       acc;
    logic       hv_write;
    logic       hv_store;
    logic       exit_write;
    logic       trap_write;
    logic       unused_addr_hi;

    // The window is 64 bytes, so only the low six address bits select a register.
    assign offset         = hyper_addr[5:0];
    assign unused_addr_hi = ^hyper_addr[7:6];

    assign acc        = hyper_cs & ready;
    assign hv_write   = acc & cpu_write & hyper_mode;
    assign hv_store   = hv_write & (offset != OFF_REASON) & (offset != OFF_EXIT);
    assign exit_write = hv_write & (offset == OFF_EXIT);

`ifdef HYPER_USER_TRAP_EN
    logic hyp_reg;

    assign trap_write = acc & cpu_write & ~hyper_mode;
    assign hyp        = hyp_reg;

    // Trap request: set by a user-mode write, held until the CPU is seen in
    // hypervisor mode; hypervisor mode takes priority as it acknowledges the trap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hyp_reg <= 1'b0;
        end else if (hyper_mode) begin
            hyp_reg <= 1'b0;
        end else if (trap_write) begin
            hyp_reg <= 1'b1;
        end
    end
`else
    assign trap_write = 1'b0;
    assign hyp        = 1'b0;
`endif

    // Register file: hypervisor stores go anywhere except the reason/exit
    // slots; the reason slot is written only by a trapping user write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                regs_reg[i] <= 8'h00;
            end
        end else begin
            if (hv_store) begin
                regs_reg[offset] <= hyper_io_data_i;
            end
            if (trap_write) begin
                regs_reg[OFF_REASON] <= {2'b00, offset};
            end
        end
    end

    // Registered bus read: user mode sees 0xFF, the exit trigger reads as 0x00.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hyper_data_o <= 8'h00;
        end else if (acc && !cpu_write) begin
            if (!hyper_mode) begin
                hyper_data_o <= 8'hFF;
            end else if (offset == OFF_EXIT) begin
                hyper_data_o <= 8'h00;
            end else begin
                hyper_data_o <= regs_reg[offset];
            end
        end
    end

    // Restore sequencer: one shadow byte per ready cycle, outputs registered
    // so user_mapper_reg lines up with load_user_reg.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            load_user_reg   <= 1'b0;
            user_mapper_reg <= 8'h00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    load_user_reg <= 1'b0;
                    idx_reg       <= '0;
                    if (exit_write) begin
                        state_reg <= S_RESTORE;
                    end
                end
                S_RESTORE: begin
                    if (ready) begin
                        load_user_reg   <= 1'b1;
                        user_mapper_reg <= regs_reg[6'(idx_reg)];
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= S_IDLE;
                            idx_reg   <= '0;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        load_user_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    load_user_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hypervisor_ctrl.sv
// Directed testbench for hypervisor_ctrl with a scoreboard queue: expected
// read data / restore bytes are pushed when stimulus is driven and popped
// when the DUT presents the corresponding output.
module tb_hypervisor_ctrl;

    localparam int NUM_SHADOW = 16;

    logic       clk;
    logic       reset;
    logic       hyper_cs;
    logic [7:0] hyper_addr;
    logic [7:0] hyper_io_data_i;
    logic [7:0] hyper_data_o;
    logic       cpu_write;
    logic       ready;
    logic       hyper_mode;
    logic       hyp;
    logic       load_user_reg;
    logic [7:0] user_mapper_reg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q [$];

    hypervisor_ctrl #(.NUM_SHADOW(NUM_SHADOW)) dut (
        .clk             (clk),
        .reset           (reset),
        .hyper_cs        (hyper_cs),
        .hyper_addr      (hyper_addr),
        .hyper_io_data_i (hyper_io_data_i),
        .hyper_data_o    (hyper_data_o),
        .cpu_write       (cpu_write),
        .ready           (ready),
        .hyper_mode      (hyper_mode),
        .hyp             (hyp),
        .load_user_reg   (load_user_reg),
        .user_mapper_reg (user_mapper_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data,
                            input logic mode, input logic rdy);
        @(negedge clk);
        hyper_cs = 1'b1; hyper_addr = addr; hyper_io_data_i = data;
        cpu_write = 1'b1; ready = rdy; hyper_mode = mode;
        @(posedge clk); #1;
        $display("write addr=%02h data=%02h mode=%0d ready=%0d", addr, data, mode, rdy);
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr,
                           input logic mode, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk);
        hyper_cs = 1'b1; hyper_addr = addr; cpu_write = 1'b0; ready = 1'b1; hyper_mode = mode;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        $display("read  addr=%02h mode=%0d data=%02h", addr, mode, hyper_data_o);
        chk(tag, hyper_data_o, e);
    endtask

    task automatic bus_idle(input logic mode);
        @(negedge clk);
        hyper_cs = 1'b0; cpu_write = 1'b0; ready = 1'b1; hyper_mode = mode;
        @(posedge clk); #1;
    endtask

    // Exit write, then watch the restore stream. alt_ready toggles ready
    // each cycle (starting low); abort_at >= 0 pulls reset after that many pulses.
    task automatic exit_and_watch(input logic alt_ready, input int abort_at);
        int         pulses;
        int         cyc;
        int         bad;
        logic       rdy;
        logic [7:0] e;
        @(negedge clk);
        hyper_cs = 1'b1; hyper_addr = 8'h7F; hyper_io_data_i = 8'hAB;
        cpu_write = 1'b1; ready = 1'b1; hyper_mode = 1'b1;
        for (int i = 0; i < NUM_SHADOW; i++) exp_q.push_back(8'h10 + 8'(i));
        @(posedge clk); #1;
        $display("exit write alt_ready=%0d abort_at=%0d", alt_ready, abort_at);
        chk("load_on_exit_edge", {7'b0, load_user_reg}, 8'h00);
        pulses = 0;
        cyc    = 0;
        while (pulses < NUM_SHADOW && cyc < 80) begin
            @(negedge clk);
            rdy = alt_ready ? cyc[0] : 1'b1;
            ready = rdy;
            // A second exit write mid-sequence must not restart the stream.
            if (cyc == 3) begin
                hyper_cs = 1'b1; hyper_addr = 8'h7F; cpu_write = 1'b1;
            end else begin
                hyper_cs = 1'b0; cpu_write = 1'b0;
            end
            if (abort_at >= 0 && pulses == abort_at) begin
                reset = 1'b0;
                @(posedge clk); #1;
                chk("abort_load", {7'b0, load_user_reg}, 8'h00);
                chk("abort_mapper", user_mapper_reg, 8'h00);
                @(negedge clk);
                reset = 1'b1; hyper_cs = 1'b0; cpu_write = 1'b0; ready = 1'b1;
                exp_q.delete();
                bad = 0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    if (load_user_reg !== 1'b0) bad++;
                end
                chk("abort_stays_idle", 8'(bad), 8'h00);
                return;
            end
            @(posedge clk); #1;
            chk("load_vs_ready", {7'b0, load_user_reg}, {7'b0, rdy});
            if (load_user_reg === 1'b1) begin
                e = exp_q.pop_front();
                $display("restore pulse %0d mapper=%02h", pulses, user_mapper_reg);
                chk("restore_byte", user_mapper_reg, e);
                pulses++;
            end
            cyc++;
        end
        chk("restore_pulse_count", 8'(pulses), 8'(NUM_SHADOW));
        bus_idle(1'b1);
        chk("load_after_last", {7'b0, load_user_reg}, 8'h00);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0; hyper_cs = 1'b0; hyper_addr = 8'h00; hyper_io_data_i = 8'h00;
        cpu_write = 1'b0; ready = 1'b0; hyper_mode = 1'b1;

        // Reset held low for two clocks
        repeat (2) @(posedge clk);
        #1;
        $display("reset applied");
        chk("reset_hyp", {7'b0, hyp}, 8'h00);
        chk("reset_load", {7'b0, load_user_reg}, 8'h00);
        chk("reset_data", hyper_data_o, 8'h00);
        chk("reset_mapper", user_mapper_reg, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Hypervisor write/read, exit trigger reads as zero
        do_write(8'h42, 8'h5A, 1'b1, 1'b1);
        do_read("hv_read_42", 8'h42, 1'b1, 8'h5A);
        do_read("hv_read_7f", 8'h7F, 1'b1, 8'h00);
        do_write(8'h7E, 8'hC3, 1'b1, 1'b1);
        do_read("reason_ro", 8'h7E, 1'b1, 8'h00);

        // Ready stall: neither store nor trap
        do_write(8'h43, 8'h99, 1'b1, 1'b0);
        do_read("stall_no_store", 8'h43, 1'b1, 8'h00);
        do_write(8'h44, 8'h66, 1'b0, 1'b0);
        chk("stall_no_trap", {7'b0, hyp}, 8'h00);
        do_read("stall_reason", 8'h7E, 1'b1, 8'h00);

        // User-mode read always returns 0xFF
        do_read("user_read", 8'h42, 1'b0, 8'hFF);

`ifdef HYPER_USER_TRAP_EN
        do_write(8'h45, 8'h33, 1'b0, 1'b1);
        chk("trap_hyp_set", {7'b0, hyp}, 8'h01);
        do_read("trap_user_read", 8'h45, 1'b0, 8'hFF);
        chk("trap_hyp_holds", {7'b0, hyp}, 8'h01);
        bus_idle(1'b1);
        chk("trap_hyp_clear", {7'b0, hyp}, 8'h00);
        do_read("trap_reason", 8'h7E, 1'b1, 8'h05);
        do_read("trap_no_store", 8'h45, 1'b1, 8'h00);
        do_write(8'h41, 8'h00, 1'b0, 1'b1);
        do_write(8'h46, 8'h00, 1'b0, 1'b1);
        chk("trap_hyp_again", {7'b0, hyp}, 8'h01);
        bus_idle(1'b1);
        do_read("trap_last_wins", 8'h7E, 1'b1, 8'h06);
`else
        do_write(8'h40, 8'h77, 1'b0, 1'b1);
        chk("notrap_hyp", {7'b0, hyp}, 8'h00);
        bus_idle(1'b1);
        chk("notrap_hyp_later", {7'b0, hyp}, 8'h00);
        do_read("notrap_reason", 8'h7E, 1'b1, 8'h00);
        do_read("notrap_no_store", 8'h40, 1'b1, 8'h00);
`endif

        // Preload shadow bytes and run the restore paths
        for (int i = 0; i < NUM_SHADOW; i++) do_write(8'h40 + 8'(i), 8'h10 + 8'(i), 1'b1, 1'b1);
        do_read("preload_0f", 8'h4F, 1'b1, 8'h1F);
        exit_and_watch(1'b0, -1);
        exit_and_watch(1'b1, -1);
        exit_and_watch(1'b0, 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hypervisor_ctrl.md
# hypervisor_ctrl

Hypervisor control block for the 4510-class CPU subsystem. It decodes the 64-byte hypervisor register window at $D640–$D67F and holds the user-context shadow registers. It raises the hypervisor trap request toward the CPU and streams the saved user context back to the CPU on hypervisor exit. It sits beside the CPU on the next-cycle address/data bus; the system bus mux selects its read data one cycle after chip select.

## Interface
Parameters:
- NUM_SHADOW, 16, number of user-context shadow bytes (offsets 0x00..NUM_SHADOW-1) streamed on exit.

Ports (one clock domain; reset is synchronous and active-low):
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- hyper_cs  in  1  window select; high when CPU next address is in $D640–$D67F.
- hyper_addr  in  8  CPU next address [7:0]; offset = hyper_addr[5:0].
- hyper_io_data_i  in  8  CPU next-cycle write data.
- hyper_data_o  out  8  registered read data.
- cpu_write  in  1  CPU next-cycle write strobe.
- ready  in  1  bus ready; accesses and sequence steps occur only when high.
- hyper_mode  in  1  CPU is executing in hypervisor mode.
- hyp  out  1  trap request to CPU.
- load_user_reg  out  1  user-context restore strobe.
- user_mapper_reg  out  8  shadow byte being restored.

## Operation
- Storage: 64 × 8 register file, indexed by offset. 0x00..NUM_SHADOW-1 are shadow bytes. 0x3E is the trap reason (read-only to the bus). 0x3F is the exit trigger (write-only; reads 0x00).
- Access qualifier: acc = hyper_cs & ready. Write: acc & cpu_write.
- Hypervisor-mode write (hyper_mode=1) to offsets other than 0x3E/0x3F stores hyper_io_data_i.
- Hypervisor-mode read: hyper_data_o <= reg[offset].
- User-mode read (hyper_mode=0): hyper_data_o <= 0xFF.
- User-mode write: register file unchanged. Trap reason <= {2'b00, offset}; hyp set (see Configuration).
- hyp holds until the first cycle hyper_mode=1 is sampled, then clears.
- A new user-mode write while hyp=1 overwrites the trap reason (last write wins).
- Exit: a hypervisor-mode write to 0x3F starts the restore sequence; the written data is ignored.
  - Index idx steps 0..NUM_SHADOW-1, advancing one per cycle with ready=1.
  - Each such cycle: load_user_reg=1 and user_mapper_reg=reg[idx].
  - If ready=0: load_user_reg=0, idx holds, user_mapper_reg holds.
  - After the last index: sequence ends, load_user_reg=0.
  - Writes to 0x3F while the sequence is running are ignored.
- States: IDLE, RESTORE. IDLE→RESTORE on an exit write; RESTORE→IDLE after index NUM_SHADOW-1 is delivered.
- Reset (reset=0 on clock edge) clears all registers, idx, and outputs: hyper_data_o=0x00, hyp=0, load_user_reg=0, user_mapper_reg=0x00, state IDLE. Reset during RESTORE aborts it.

## Timing
- Read latency 1 clock: data is valid in the cycle after the qualified access, matching the registered bus_device mux.
- Write takes effect at the rising edge of the qualified cycle; a read of the same offset in the next access returns the new value.
- hyp rises 1 clock after the trapping write; it falls 1 clock after hyper_mode is sampled high.
- load_user_reg first asserts 1 clock after the exit write. With ready held high, the restore takes exactly NUM_SHADOW cycles. user_mapper_reg is registered, aligned with load_user_reg.

## Configuration
- HYPER_USER_TRAP_EN defined: user-mode writes to the window latch the trap reason and assert hyp as above.
- Undefined: hyp is tied 0. User-mode writes are ignored and the trap reason stays 0x00. All other behaviour is unchanged.

## Test plan
- Reset: hold reset=0 for 2 clocks -> hyp=0, load_user_reg=0, hyper_data_o=0x00, user_mapper_reg=0x00.
- Hypervisor write/read: hyper_mode=1, write 0x5A to $D642, then read $D642 -> hyper_data_o=0x5A one clock after the read access. Read $D67F -> 0x00.
- User trap (macro defined): hyper_mode=0, write to $D645 -> hyp=1 next clock; reg 0x3E reads 0x05 once hyper_mode=1; hyp clears 1 clock after hyper_mode rises. User read -> 0xFF.
- Ready stall: write with ready=0 -> no register change and no trap. Alternate ready each cycle during restore -> load_user_reg pulses only on ready=1 cycles; 16 pulses with values reg[0..15] in order.
- Exit restore: preload shadow bytes 0x00..0x0F with 0x10..0x1F, write $D67F with ready=1 -> 16 consecutive cycles of load_user_reg=1 with user_mapper_reg=0x10..0x1F, then 0. Assert reset=0 mid-sequence -> load_user_reg=0 on the next clock.
- Macro undefined: user-mode write to $D640 -> hyp stays 0 and reg 0x3E stays 0x00.
